lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  Load/store initiator driving the single-port word memory (rw/addr/data in, registered out) from the core pipeline.
//  Converts byte-addressed RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
//  Sub-word stores use read-modify-write; loads return sign/zero-extended data. Sits between EX stage and data memory.
// PARAMETERS
//  MEM_WORDS   1024  words in target memory; word index >= MEM_WORDS is an access error
// PORTS
//  clk_i         in   1   clock, rising edge
//  rst_ni        in   1   reset, asynchronous, active-low
//  req_valid_i   in   1   request present
//  req_ready_o   out  1   request accepted on edge when valid&ready
//  req_we_i      in   1   1=store, 0=load
//  req_funct3_i  in   3   RV32I funct3 (size/sign)
//  req_addr_i    in   32  byte address
//  req_wdata_i   in   32  store data (low bytes used for SB/SH)
//  resp_valid_o  out  1   one-cycle completion pulse, no backpressure
//  resp_rdata_o  out  32  load result (0 for stores/errors)
//  resp_err_o    out  1   misaligned, illegal funct3 or out-of-range; qualified by resp_valid_o
//  mem_rw_o      out  1   0=READ, 1=WRITE
//  mem_addr_o    out  32  word index = addr[31:2]
//  mem_data_o    out  32  write data word
//  mem_out_i     in   32  memory read data, valid cycle after READ presented
// BEHAVIOUR
//  Reset: state IDLE; req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, mem_rw_o=0, mem_addr_o=0, mem_data_o=0.
//  FSM: IDLE -> RD -> CAP (load) | RD -> WR (SB/SH) | WR (SW) | IDLE (error); CAP/WR -> IDLE.
//  req_ready_o = (state==IDLE); request fields registered on acceptance; pipeline holds nothing after.
//  RD: mem_rw_o=0, mem_addr_o=word index. CAP: extract lane of mem_out_i, extend, register into resp_rdata_o.
//  WR: mem_rw_o=1; SW writes req_wdata_i; SB/SH merge new bytes into mem_out_i (old word), others unchanged.
//  mem_rw_o=1 only in WR state; all other states drive READ.
//  Latency (accept edge at end of cycle N): load, SB, SH -> resp_valid_o in N+3; SW -> N+2; error -> N+1, no memory access.
//  resp_valid_o set on the same edge FSM returns to IDLE: new request accepted in the response cycle (back-to-back).
//  Lanes: byte = addr[1:0]*8; half = addr[1]*16. LB/LH sign-extend, LBU/LHU zero-extend.
//  Errors: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; funct3 011/110/111; store funct3[2]=1; addr[31:2]>=MEM_WORDS.
//  Reset mid-operation: FSM to IDLE asynchronously, mem_rw_o drops to 0 before next edge -> no partial write; no resp.
//  req_valid_i while busy: ignored (not accepted), no state change.
// CONFIGURATION
//  LSU_PERF_CNT_EN defined: extra outputs perf_ld_o[31:0], perf_st_o[31:0], perf_err_o[31:0]; incremented on resp_valid_o
//   by type, wrap at 2^32, reset to 0.
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  lsu_pkg: funct3 enum (LB..LHU, SB..SW), FSM state enum, MEM_READ=1'b0/MEM_WRITE=1'b1.
//  Sub-module lsu_align (combinational): load lane extract + extend, store byte merge; unit-testable alone.
// TESTING
//  Memory model: behavioural 1-cycle registered-read word array matching the core memory.
//  1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem[4]=0xDEADBEEF; rdata 0xDEADBEEF; SW resp N+2, LW resp N+3.
//  2. SB 0x13 data 0x000000AA onto 0xDEADBEEF -> mem[4]=0xAAADBEEF; LB 0x13 -> 0xFFFFFFAA; LBU 0x13 -> 0x000000AA.
//  3. SH 0x12 data 0x1234, then LH 0x12 -> 0x00001234; LH 0x11 -> err=1 at N+1, mem_rw_o never 1.
//  4. Back-to-back: LW issued in resp cycle of prior SW -> accepted same cycle; req_valid during busy not accepted.
//  5. rst_ni low during WR cycle of SB -> mem_rw_o=0 before edge, memory word unchanged, no resp_valid_o.
//  6. LW addr 0x1000 (word 1024) -> err=1, rdata 0; with LSU_PERF_CNT_EN perf_err_o increments to 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
//   Shared types for the load/store unit memory master:
//     - RV32I funct3 encodings for loads (LB..LHU) and stores (SB..SW)
//     - FSM state encoding of lsu_mem_master
//     - memory command encoding (MEM_READ / MEM_WRITE)
//     - lsu_fmt_err(): size/alignment/encoding legality check of a request
//       (address range is checked by the top, which owns MEM_WORDS)
// ----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } ld_funct3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } st_funct3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CAP  = 2'd2,
        S_WR   = 2'd3
    } lsu_state_e;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    // 1 when the funct3 is not a legal encoding for the access direction, or
    // when the byte offset is not aligned to the access size.
    function automatic logic lsu_fmt_err(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] off);
        logic err;
        err = 1'b0;
        case (funct3)
            F3_LB:   err = 1'b0;
            F3_LH:   err = off[0];
            F3_LW:   err = (off != 2'b00);
            F3_LBU:  err = we;              // no unsigned store forms
            F3_LHU:  err = we | off[0];
            default: err = 1'b1;            // 011 / 110 / 111
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
//   Combinational lane logic for the LSU.
//   Ports:
//     funct3_i     RV32I funct3 of the registered request
//     byte_off_i   byte address bits [1:0]
//     old_word_i   word read from memory
//     wdata_i      store data (low bytes used for SB/SH)
//     load_data_o  selected lane of old_word_i, sign/zero extended
//     store_word_o old_word_i with the stored bytes replaced (SW: wdata_i)
// ----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [31:0] byte_shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;

    // Load side
    always_comb begin
        byte_shifted = old_word_i >> {byte_off_i, 3'b000};
        lane_b       = byte_shifted[7:0];
        lane_h       = byte_off_i[1] ? old_word_i[31:16] : old_word_i[15:0];
        case (funct3_i)
            F3_LB:   load_data_o = {{24{lane_b[7]}}, lane_b};
            F3_LH:   load_data_o = {{16{lane_h[15]}}, lane_h};
            F3_LW:   load_data_o = old_word_i;
            F3_LBU:  load_data_o = {24'h0, lane_b};
            F3_LHU:  load_data_o = {16'h0, lane_h};
            default: load_data_o = 32'h0;
        endcase
    end

    // Store side: replicate the store data across all lanes so each lane only
    // has to choose between new and old byte.
    always_comb begin
        case (funct3_i[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << byte_off_i;
                wdata_rep = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                byte_en   = byte_off_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_i[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                wdata_rep = wdata_i;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign store_word_o[gi*8 +: 8] = byte_en[gi] ? wdata_rep[gi*8 +: 8]
                                                     : old_word_i[gi*8 +: 8];
    end

endmodule

// File: rtl/lsu_mem_master.sv
// ----------------------------------------------------------------------------
// lsu_mem_master
//   Load/store initiator between the EX stage and a single-port word memory
//   with registered read data. Byte-addressed RV32I loads/stores become word
//   accesses; SB/SH use read-modify-write.
//   Ports:
//     clk_i, rst_ni                 clock, async active-low reset
//     req_valid_i / req_ready_o     request handshake (ready only in IDLE)
//     req_we_i, req_funct3_i        direction and size/sign
//     req_addr_i, req_wdata_i       byte address, store data
//     resp_valid_o                  one-cycle completion pulse
//     resp_rdata_o, resp_err_o      load result / error flag
//     mem_rw_o, mem_addr_o          memory command and word index
//     mem_data_o, mem_out_i         memory write data / registered read data
//   Optional (macro LSU_PERF_CNT_EN): perf_ld_o, perf_st_o, perf_err_o
//     completion counters per response type.
//   Latency from the accept edge: load/SB/SH 3, SW 2, error 1 cycle.
// ----------------------------------------------------------------------------
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_rw_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_out_i
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0] perf_ld_o,
    output logic [31:0] perf_st_o,
    output logic [31:0] perf_err_o
`endif
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_err = lsu_fmt_err(req_we_i, req_funct3_i, req_addr_i[1:0])
                   | ({2'b00, req_addr_i[31:2]} >= MEM_WORDS_W);

    lsu_align u_align (
        .funct3_i     (funct3_q),
        .byte_off_i   (addr_q[1:0]),
        .old_word_i   (mem_out_i),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    if (req_err) begin
                        // Rejected without touching memory; stay ready.
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we_i && (req_funct3_i == F3_SW)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:   state_d = we_q ? S_WR : S_CAP;
            S_CAP: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
                state_d      = S_IDLE;
            end
            S_WR: begin
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;

    // Memory command decoded straight from the state register so an
    // asynchronous reset withdraws a pending write before the next edge.
    assign mem_rw_o   = (state_q == S_WR) ? MEM_WRITE : MEM_READ;
    assign mem_addr_o = ((state_q == S_RD) || (state_q == S_WR))
                      ? {2'b00, addr_q[31:2]} : 32'h0;
    assign mem_data_o = (state_q == S_WR) ? store_word : 32'h0;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_ld_q, perf_ld_d;
    logic [31:0] perf_st_q, perf_st_d;
    logic [31:0] perf_err_q, perf_err_d;

    // Counted on the edge that raises resp_valid_o, so the counter already
    // includes a request during its response cycle.
    always_comb begin
        perf_ld_d  = perf_ld_q;
        perf_st_d  = perf_st_q;
        perf_err_d = perf_err_q;
        if (state_q == S_CAP) begin
            perf_ld_d = perf_ld_q + 32'd1;
        end
        if (state_q == S_WR) begin
            perf_st_d = perf_st_q + 32'd1;
        end
        if ((state_q == S_IDLE) && req_valid_i && req_err) begin
            perf_err_d = perf_err_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_ld_q  <= 32'h0;
            perf_st_q  <= 32'h0;
            perf_err_q <= 32'h0;
        end else begin
            perf_ld_q  <= perf_ld_d;
            perf_st_q  <= perf_st_d;
            perf_err_q <= perf_err_d;
        end
    end

    assign perf_ld_o  = perf_ld_q;
    assign perf_st_o  = perf_st_q;
    assign perf_err_o = perf_err_q;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_master
//   Directed + randomized stimulus for lsu_mem_master against a byte-level
//   reference memory. A word array with registered read stands in for the
//   data memory driven by the DUT.
// ----------------------------------------------------------------------------
module tb_lsu_mem_master;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        mem_rw_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_out_i;

    always #5 clk_i = ~clk_i;

    lsu_mem_master #(.MEM_WORDS(1024)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .mem_rw_o     (mem_rw_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_out_i    (mem_out_i)
    );

    // Data memory: 1024 words, write or registered read each edge.
    logic [31:0] mem [0:1023];
    always @(posedge clk_i) begin
        if (mem_rw_o) begin
            if (mem_addr_o < 32'd1024) mem[mem_addr_o[9:0]] <= mem_data_o;
        end else begin
            mem_out_i <= (mem_addr_o < 32'd1024) ? mem[mem_addr_o[9:0]] : 32'h0;
        end
    end

    // Reference model: plain little-endian byte array.
    logic [7:0] ref_bytes [0:4095];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int ref_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (we && f3[2]) return 1'b1;
        sz = ref_size(f3);
        if ((addr % sz) != 0) return 1'b1;
        if ((addr / 4) >= 1024) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        longint unsigned v;
        int sz;
        sz = ref_size(f3);
        v  = 0;
        for (int i = 0; i < sz; i++) v = v | (longint'(ref_bytes[addr + i]) << (8 * i));
        if (!f3[2] && sz < 4) begin
            if (((v >> (8 * sz - 1)) & 1) == 1) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * sz));
        end
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        int sz;
        sz = ref_size(f3);
        for (int i = 0; i < sz; i++) ref_bytes[addr + i] = 8'(wdata >> (8 * i));
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    endfunction

    // Issue one request; call and return at a falling edge. With poke set, a
    // junk SW to word 31 is held on the request port while the LSU is busy.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit poke_busy, input string name);
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat, exp_writes, lat, writes, guard;
        bit          poke;
        guard = 0;
        while (!req_ready_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        check_eq({name, "_ready"}, {31'h0, req_ready_o}, 32'h1);
        exp_err    = ref_err(we, f3, addr);
        exp_lat    = exp_err ? 1 : ((we && f3[1:0] == 2'b10) ? 2 : 3);
        exp_writes = (!exp_err && we) ? 1 : 0;
        exp_rdata  = (!exp_err && !we) ? ref_load(f3, addr) : 32'h0;
        poke       = poke_busy && !exp_err;
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        @(posedge clk_i);
        lat    = 1;
        writes = 0;
        @(negedge clk_i);
        req_valid_i = poke;
        if (poke) begin
            req_we_i     = 1'b1;
            req_funct3_i = 3'b010;
            req_addr_i   = 32'h0000_007C;
            req_wdata_i  = $urandom | 32'h1;
        end
        while (!resp_valid_o && lat < 8) begin
            if (poke) check_eq({name, "_busy_ready"}, {31'h0, req_ready_o}, 32'h0);
            if (mem_rw_o) writes++;
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        if (mem_rw_o) writes++;
        req_valid_i = 1'b0;
        check_eq({name, "_lat"},    32'(lat),    32'(exp_lat));
        check_eq({name, "_err"},    {31'h0, resp_err_o}, {31'h0, exp_err});
        check_eq({name, "_rdata"},  resp_rdata_o, exp_rdata);
        check_eq({name, "_writes"}, 32'(writes), 32'(exp_writes));
        if (!exp_err && we) ref_store(f3, addr, wdata);
        $display("[TB] txn %s we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> err=%0d rdata=0x%08h lat=%0d",
                 name, we, f3, addr, wdata, resp_err_o, resp_rdata_o, lat);
    endtask

    initial begin
        logic [31:0] addr;
        logic [2:0]  f3;
        logic        we;
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'h0;
        req_wdata_i  = 32'h0;
        mem_out_i    = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'h0;

        repeat (2) @(negedge clk_i);
        check_eq("rst_ready",  {31'h0, req_ready_o},  32'h1);
        check_eq("rst_rvalid", {31'h0, resp_valid_o}, 32'h0);
        check_eq("rst_rdata",  resp_rdata_o,          32'h0);
        check_eq("rst_err",    {31'h0, resp_err_o},   32'h0);
        check_eq("rst_rw",     {31'h0, mem_rw_o},     32'h0);
        check_eq("rst_maddr",  mem_addr_o,            32'h0);
        check_eq("rst_mdata",  mem_data_o,            32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // SW then LW back-to-back
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, "sw_10");
        check_eq("b2b_ready", {31'h0, req_ready_o}, 32'h1);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, "lw_10");
        check_eq("mem4_sw", mem[4], 32'hDEADBEEF);

        // Byte store into the top lane, signed/unsigned byte loads
        do_req(1'b1, 3'b000, 32'h13, 32'h000000AA, 1'b0, "sb_13");
        check_eq("mem4_sb", mem[4], 32'hAAADBEEF);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, "lb_13");
        check_eq("lb_13_val", resp_rdata_o, 32'hFFFFFFAA);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, "lbu_13");
        check_eq("lbu_13_val", resp_rdata_o, 32'h000000AA);

        // Half store/load and misaligned half
        do_req(1'b1, 3'b001, 32'h12, 32'h00001234, 1'b0, "sh_12");
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, "lh_12");
        check_eq("lh_12_val", resp_rdata_o, 32'h00001234);
        do_req(1'b0, 3'b001, 32'h11, 32'h0, 1'b0, "lh_11");

        // Requests held during busy cycles must be ignored
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, "lw_busy");
        do_req(1'b1, 3'b000, 32'h21, 32'h5A, 1'b1, "sb_busy");

        // Out-of-range word
        do_req(1'b0, 3'b010, 32'h1000, 32'h0, 1'b0, "lw_oor");

        // Reset asserted during the write cycle of an SB
        do_req(1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0, "sw_20");
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'h22;
        req_wdata_i  = 32'h000000EE;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_mid_wr_state", {31'h0, mem_rw_o}, 32'h1);
        #1 rst_ni = 1'b0;
        #1;
        check_eq("rst_mid_rw",    {31'h0, mem_rw_o},     32'h0);
        check_eq("rst_mid_ready", {31'h0, req_ready_o},  32'h1);
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_mid_mem",    mem[8],                32'h11223344);
        check_eq("rst_mid_rvalid", {31'h0, resp_valid_o}, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_eq("rst_mid_rvalid2", {31'h0, resp_valid_o}, 32'h0);
        $display("[TB] txn reset_during_sb mem[8]=0x%08h", mem[8]);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)
                addr = (32'($urandom_range(1024, 1100)) << 2) | 32'($urandom_range(0, 3));
            else
                addr = (32'($urandom_range(0, 23)) << 2) | 32'($urandom_range(0, 3));
            do_req(we, f3, addr, $urandom, ($urandom_range(0, 7) == 0), "rnd");
        end

        for (int w = 0; w < 32; w++) check_eq("final_mem", mem[w], ref_word(w));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
